// File: rtl/ceres_param.sv
// Shared core parameters: datapath width, regfile geometry and write-back arbiter defaults.
package ceres_param;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned REG_AW          = 5;
  localparam int unsigned NUM_REGS        = 32;
  localparam int unsigned WB_FIFO_DEPTH   = 2;
  localparam int unsigned WB_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_PEND,
    WB_HOLD
  } wb_arb_state_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending long-latency result FIFO with destination-register mask for hazard detection.
module wb_pend_fifo
  import ceres_param::*;
#(
  parameter int unsigned DEPTH = WB_FIFO_DEPTH
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  wb_entry_t           push_entry_i,
  input  logic                pop_i,
  output wb_entry_t           head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                one_o,
  output logic [NUM_REGS-1:0] mask_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] valid_q;
  wb_entry_t        mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign one_o   = (count_q == CW'(1));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CW'(1);
      if (do_pop)  valid_q[rptr_q] <= 1'b0;
      if (do_push) valid_q[wptr_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= push_entry_i;
  end

  // x0 never creates a hazard, so it is left out of the mask.
  always_comb begin
    mask_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (mem_q[i].rd != '0)) mask_o[mem_q[i].rd] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter between the pipeline WB stage and long-latency unit results.
module wb_arbiter
  import ceres_param::*;
#(
  parameter int unsigned FIFO_DEPTH   = WB_FIFO_DEPTH,
  parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pipe_we_i,
  input  logic [4:0]        pipe_rd_i,
  input  logic [XLEN-1:0]   pipe_data_i,
  input  logic              lu_valid_i,
  input  logic [4:0]        lu_rd_i,
  input  logic [XLEN-1:0]   lu_data_i,
  output logic              lu_ready_o,
  output logic              pipe_hold_o,
  output logic              rf_we_o,
  output logic [4:0]        rf_rd_o,
  output logic [XLEN-1:0]   rf_data_o,
  output logic [31:0]       pend_mask_o
);

  localparam int unsigned SW         = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned STARVE_THR = (STARVE_LIMIT >= 2) ? STARVE_LIMIT - 2 : 0;

  wb_arb_state_e state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  wb_entry_t     head;
  logic          full;
  logic          empty;
  logic          one;
  logic          push;
  logic          pop;
  logic          sel_we;

  assign lu_ready_o  = ~full;
  assign push        = lu_valid_i & ~full;
  assign pipe_hold_o = (state_q == WB_HOLD);

  wb_pend_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (push),
    .push_entry_i ('{rd: lu_rd_i, data: lu_data_i}),
    .pop_i        (pop),
    .head_o       (head),
    .full_o       (full),
    .empty_o      (empty),
    .one_o        (one),
    .mask_o       (pend_mask_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= WB_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Write-port select and FSM; the state only sets priority, the mux itself is combinational.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    pop       = 1'b0;
    sel_we    = 1'b0;
    rf_rd_o   = pipe_rd_i;
    rf_data_o = pipe_data_i;

    if (pipe_hold_o) begin
      pop       = ~empty;
      sel_we    = ~empty;
      rf_rd_o   = head.rd;
      rf_data_o = head.data;
    end else if (pipe_we_i) begin
      sel_we = 1'b1;
    end else if (!empty) begin
      pop       = 1'b1;
      sel_we    = 1'b1;
      rf_rd_o   = head.rd;
      rf_data_o = head.data;
    end

    case (state_q)
      WB_IDLE: begin
        starve_d = '0;
        if (push) state_d = WB_PEND;
      end
      WB_PEND: begin
        if (pop) begin
          starve_d = '0;
          if (one && !push) state_d = WB_IDLE;
        end else begin
          starve_d = starve_q + SW'(1);
          if (starve_q >= SW'(STARVE_THR)) state_d = WB_HOLD;
        end
      end
      WB_HOLD: begin
        starve_d = '0;
        state_d  = (one && !push) ? WB_IDLE : WB_PEND;
      end
      default: begin
        state_d  = WB_IDLE;
        starve_d = '0;
      end
    endcase
  end

  // Writes to x0 are suppressed, and nothing reaches the regfile while reset is asserted.
  assign rf_we_o = sel_we & (rf_rd_o != 5'd0) & rst_ni;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed long-latency/pipe write scenarios.
module tb_wb_arbiter;
  import ceres_param::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            pipe_we;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            lu_valid;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_data;
  logic            lu_ready;
  logic            hold;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_data;
  logic [31:0]     pend_mask;

  int total = 0;
  int bad   = 0;

  wb_entry_t exp_q[$];
  wb_entry_t mon_e;

  wb_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .pipe_we_i   (pipe_we),
    .pipe_rd_i   (pipe_rd),
    .pipe_data_i (pipe_data),
    .lu_valid_i  (lu_valid),
    .lu_rd_i     (lu_rd),
    .lu_data_i   (lu_data),
    .lu_ready_o  (lu_ready),
    .pipe_hold_o (hold),
    .rf_we_o     (rf_we),
    .rf_rd_o     (rf_rd),
    .rf_data_o   (rf_data),
    .pend_mask_o (pend_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one long-latency result; only called when the bench knows it will be accepted.
  task automatic push_lu(input logic [4:0] rd, input logic [XLEN-1:0] data);
    lu_valid = 1'b1;
    lu_rd    = rd;
    lu_data  = data;
    if (rd != 5'd0) exp_q.push_back('{rd: rd, data: data});
  endtask

  // Monitor: every regfile write is either the live pipe write or the next queued result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pipe_we && !hold && pipe_rd != 5'd0) begin
        chk("pipe_we", 32'(rf_we), 32'd1);
        chk("pipe_rd", 32'(rf_rd), 32'(pipe_rd));
        chk("pipe_data", rf_data, pipe_data);
      end else if (rf_we) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got rd=%0d data=%0h want none", rf_rd, rf_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("lu_rd", 32'(rf_rd), 32'(mon_e.rd));
          chk("lu_data", rf_data, mon_e.data);
        end
      end
      if (rf_we) chk("rd_nonzero", 32'(rf_rd != 5'd0), 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    pipe_we   = 1'b1;
    pipe_rd   = 5'd3;
    pipe_data = 32'hA000_0003;
    lu_valid  = 1'b0;
    lu_rd     = 5'd0;
    lu_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", 32'(hold), 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_ready", 32'(lu_ready), 32'd1);
    chk("rst_mask", pend_mask, 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(WB_IDLE));
    pipe_we = 1'b0;
    rst_n   = 1'b1;
    tick();

    // Pipe-idle drain.
    push_lu(5'd5, 32'h0000_1234);
    @(negedge clk); chk("drain_ready", 32'(lu_ready), 32'd1); chk("drain_we0", 32'(rf_we), 32'd0);
    tick();
    lu_valid = 1'b0;
    @(negedge clk); chk("drain_mask", pend_mask, 32'h20); chk("drain_we", 32'(rf_we), 32'd1);
    tick();
    @(negedge clk); chk("drain_mask0", pend_mask, 32'd0); chk("drain_idle", 32'(dut.state_q), 32'(WB_IDLE));
    tick();

    // Starvation with a continuously busy pipe.
    pipe_we   = 1'b1;
    pipe_rd   = 5'd3;
    pipe_data = 32'hA000_0003;
    push_lu(5'd7, 32'h0000_0777);
    @(negedge clk); chk("st_hold_t0", 32'(hold), 32'd0);
    tick();
    lu_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); chk("st_hold_pre", 32'(hold), 32'd0); chk("st_mask", pend_mask, 32'h80);
      tick();
    end
    @(negedge clk); chk("st_hold", 32'(hold), 32'd1); chk("st_rd", 32'(rf_rd), 32'd7);
    tick();
    @(negedge clk); chk("st_hold_off", 32'(hold), 32'd0); chk("st_pipe_rd", 32'(rf_rd), 32'd3);
    chk("st_idle", 32'(dut.state_q), 32'(WB_IDLE)); chk("st_mask0", pend_mask, 32'd0);
    tick();

    // Full FIFO back-pressure.
    pipe_rd   = 5'd4;
    pipe_data = 32'hA000_0004;
    push_lu(5'd10, 32'h0000_0100);
    @(negedge clk); chk("full_rdy0", 32'(lu_ready), 32'd1);
    tick();
    push_lu(5'd11, 32'h0000_0101);
    @(negedge clk); chk("full_rdy1", 32'(lu_ready), 32'd1);
    tick();
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h0000_0109;
    @(negedge clk); chk("full_rdy2", 32'(lu_ready), 32'd0); chk("full_mask2", pend_mask, 32'hC00);
    tick();
    @(negedge clk); chk("full_rdy3", 32'(lu_ready), 32'd0); chk("full_hold3", 32'(hold), 32'd0);
    tick();
    @(negedge clk); chk("full_rdy4", 32'(lu_ready), 32'd0); chk("full_hold4", 32'(hold), 32'd1);
    tick();
    @(negedge clk); chk("full_rdy5", 32'(lu_ready), 32'd1); chk("full_mask5", pend_mask, 32'h800);
    exp_q.push_back('{rd: 5'd9, data: 32'h0000_0109});
    tick();
    lu_valid = 1'b0;
    pipe_we  = 1'b0;
    @(negedge clk); chk("full_pop11", 32'(rf_rd), 32'd11); chk("full_mask6", pend_mask, 32'hA00);
    tick();
    @(negedge clk); chk("full_pop9", 32'(rf_rd), 32'd9); chk("full_mask7", pend_mask, 32'h200);
    tick();
    @(negedge clk); chk("full_idle", 32'(dut.state_q), 32'(WB_IDLE)); chk("full_mask8", pend_mask, 32'd0);
    tick();

    // x0 results and pipe writes never reach the regfile.
    pipe_we   = 1'b1;
    pipe_rd   = 5'd0;
    pipe_data = 32'hA000_0000;
    push_lu(5'd0, 32'h0000_0055);
    @(negedge clk); chk("x0_we0", 32'(rf_we), 32'd0);
    tick();
    lu_valid = 1'b0;
    pipe_we  = 1'b0;
    @(negedge clk); chk("x0_we1", 32'(rf_we), 32'd0); chk("x0_mask", pend_mask, 32'd0);
    chk("x0_pend", 32'(dut.state_q), 32'(WB_PEND));
    tick();
    @(negedge clk); chk("x0_idle", 32'(dut.state_q), 32'(WB_IDLE));
    chk("x0_empty", 32'(dut.u_fifo.count_q), 32'd0);
    tick();

    // Back-to-back push and pop at count 1.
    for (int k = 0; k < 10; k++) begin
      push_lu(5'(12 + k), 32'h0000_2800 + 32'(k));
      @(negedge clk);
      chk("pp_ready", 32'(lu_ready), 32'd1);
      if (k > 0) begin
        chk("pp_count", 32'(dut.u_fifo.count_q), 32'd1);
        chk("pp_we", 32'(rf_we), 32'd1);
      end
      tick();
    end
    lu_valid = 1'b0;
    @(negedge clk); chk("pp_last_we", 32'(rf_we), 32'd1);
    tick();
    @(negedge clk); chk("pp_idle", 32'(dut.state_q), 32'(WB_IDLE));
    chk("pp_drained", 32'(exp_q.size()), 32'd0);
    tick();

    // Reset while holding with two entries pending.
    pipe_we   = 1'b1;
    pipe_rd   = 5'd6;
    pipe_data = 32'hA000_0006;
    push_lu(5'd20, 32'h0000_0300);
    tick();
    push_lu(5'd21, 32'h0000_0301);
    tick();
    lu_valid = 1'b0;
    tick();
    tick();
    @(negedge clk); chk("rh_hold", 32'(hold), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rh_hold0", 32'(hold), 32'd0);
    chk("rh_we0", 32'(rf_we), 32'd0);
    chk("rh_ready", 32'(lu_ready), 32'd1);
    chk("rh_mask", pend_mask, 32'd0);
    chk("rh_state", 32'(dut.state_q), 32'(WB_IDLE));
    exp_q.delete();
    tick();
    chk("rh_we_rst", 32'(rf_we), 32'd0);
    rst_n = 1'b1;
    @(negedge clk); chk("rh_after_we", 32'(rf_we), 32'd1); chk("rh_after_mask", pend_mask, 32'd0);
    tick();
    pipe_we = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, which sets the number of pending long-latency results (power of two, at least 2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, which sets the cycles a pending entry may wait before the pipeline is held (at least 1).
REQ-003 SHALL have the following ports, one per line:
 clk_i  in  1  single clock, rising edge
 rst_ni  in  1  asynchronous reset, active-low
 pipe_we_i  in  1  pipeline WB stage requests a regfile write
 pipe_rd_i  in  5  pipeline destination register
 pipe_data_i  in  XLEN  pipeline write data
 lu_valid_i  in  1  long-latency unit (div/AMO return) result valid
 lu_rd_i  in  5  long-latency destination register
 lu_data_i  in  XLEN  long-latency result
 lu_ready_o  out  1  arbiter accepts a long-latency result
 pipe_hold_o  out  1  stall request to the hazard unit; WB instruction re-presented next cycle
 rf_we_o  out  1  regfile write enable
 rf_rd_o  out  5  regfile write address
 rf_data_o  out  XLEN  regfile write data
 pend_mask_o  out  32  bit n set while any FIFO entry targets xn, for hazard detection

Function
REQ-004 Long-latency results SHALL enter a FIFO of FIFO_DEPTH entries; a push occurs when lu_valid_i and lu_ready_o are both 1.
REQ-005 lu_ready_o SHALL equal not-full; a pop in the same cycle SHALL NOT raise ready, and there SHALL be no fall-through.
REQ-006 A result SHALL reach rf_we_o no earlier than the cycle after its push (minimum latency 1).
REQ-007 The write-port select SHALL be combinational:
 - hold active: the FIFO head is written and the pipe write is dropped.
 - otherwise, pipe_we_i=1: the pipe write is performed.
 - otherwise, FIFO non-empty: the head is written (pop).
 - otherwise: rf_we_o=0.
REQ-008 rf_we_o SHALL be 0 for any write with rd=0; a FIFO pop with rd=0 SHALL still occur.
REQ-009 FSM states:
 - IDLE: FIFO empty.
 - PEND: FIFO non-empty, pipe has priority.
 - HOLD: pipe_hold_o=1.
REQ-010 IDLE SHALL go to PEND on a push.
REQ-011 PEND SHALL go to IDLE when a pop empties the FIFO and no push occurs that cycle.
REQ-012 In PEND, a starve counter SHALL increment each cycle without a pop and clear on any pop.
REQ-013 PEND SHALL go to HOLD when the counter reaches STARVE_LIMIT-1 and no pop occurs that cycle.
REQ-014 HOLD SHALL last exactly one cycle and pop one entry, then go to PEND if the FIFO is still non-empty (push counted), else to IDLE; the counter SHALL clear on HOLD exit.
REQ-015 pipe_hold_o SHALL be 1 only in HOLD; pipe_hold_o SHALL be a registered-state decode.
REQ-016 pend_mask_o SHALL be the OR of one-hot(rd) over valid FIFO entries, rd=0 excluded, and SHALL update the cycle after a push or pop.
REQ-017 A simultaneous push and pop SHALL keep the count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 The block SHALL have no flush input: entries are results of committed instructions and SHALL NOT be discarded on a pipeline flush.

Reset
REQ-019 Asynchronous reset SHALL put:
 - FSM in IDLE;
 - count, pointers and starve counter at 0;
 - lu_ready_o=1, pipe_hold_o=0, rf_we_o=0, pend_mask_o=0.
REQ-020 An assertion of reset mid-operation SHALL discard all FIFO entries, and no rf write SHALL occur while rst_ni=0.
REQ-021 FIFO data storage SHALL NOT require reset.

Structure
REQ-022 The FSM state enum (wb_arb_state_e) and the STARVE_LIMIT and FIFO_DEPTH defaults SHALL reside in ceres_param; XLEN SHALL come from ceres_param.
REQ-023 The FIFO SHALL be one sub-module, wb_pend_fifo (storage, pointers, count, mask generation); the arbiter top SHALL hold the FSM, starve counter and select mux.

Verification
REQ-024 Pipe-idle drain: push rd=5, data 0x1234, pipe_we_i=0 -> next cycle rf_we_o=1, rf_rd_o=5, rf_data_o=0x1234; pend_mask_o[5]=1 for one cycle, then 0; FSM back to IDLE.
REQ-025 Starvation: one push with rd=7, pipe_we_i=1 continuously -> pipe_hold_o=1 exactly STARVE_LIMIT (4) cycles after the push cycle; in that cycle rd=7 is written and the pipe write is dropped; the next cycle the pipe write proceeds.
REQ-026 Full: two pushes with pipe_we_i=1 -> lu_ready_o=0; lu_valid_i held with rd=9 stays unaccepted until a pop; no data lost; write order follows FIFO order.
REQ-027 x0: push rd=0 and pipe write rd=0 -> rf_we_o never 1; the FIFO still empties; pend_mask_o stays 0.
REQ-028 Simultaneous push and pop at count=1, repeated for 10 cycles -> count stays 1, pointers wrap, all 10 results are written in order.
REQ-029 Reset mid-operation: rst_ni=0 while in HOLD with 2 entries -> immediately IDLE, pipe_hold_o=0, rf_we_o=0, lu_ready_o=1, pend_mask_o=0.
